// File: rtl/branch_compare_seq.sv
// branch_compare_seq: chunked MSB-first branch comparator producing BrEq/BrLt/BrLtU with start/busy/done handshake
module branch_compare_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic            BrEq,
    output logic            BrLt,
    output logic            BrLtU
);
    localparam int N  = XLEN / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
    logic [CHUNK-1:0]  ca, cb;
    logic              top;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        ltu_d   = ltu_q;
        ca      = CHUNK'(a_q >> (CHUNK * int'(idx_q)));
        cb      = CHUNK'(b_q >> (CHUNK * int'(idx_q)));
        top     = idx_q == IW'(N - 1);
        case (state_q)
            IDLE: if (start) begin
                a_d     = rs1;
                b_d     = rs2;
                idx_d   = IW'(N - 1);
                state_d = CMP;
            end
            CMP: if (ca != cb) begin
                // only the top chunk carries the sign bit
                eq_d    = 1'b0;
                ltu_d   = ca < cb;
                lt_d    = top ? ($signed(ca) < $signed(cb)) : (ca < cb);
                state_d = DONE;
            end else if (idx_q == '0) begin
                eq_d    = 1'b1;
                lt_d    = 1'b0;
                ltu_d   = 1'b0;
                state_d = DONE;
            end else begin
                idx_d = idx_q - IW'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IW'(N - 1);
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
        end
    end

    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign BrEq  = eq_q;
    assign BrLt  = lt_q;
    assign BrLtU = ltu_q;
endmodule

// File: tb/tb_branch_compare_seq.sv
// tb_branch_compare_seq: directed self-checking bench for branch_compare_seq
module tb_branch_compare_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, done, BrEq, BrLt, BrLtU;
    int          n_checks = 0;
    int          n_fail = 0;

    branch_compare_seq dut (
        .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .BrEq(BrEq), .BrLt(BrLt), .BrLtU(BrLtU)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(posedge clk) #1;
        start = 1'b1;
        rs1   = x;
        rs2   = y;
        @(posedge clk) #1;
        start = 1'b0;
        rs1   = ~x;
        rs2   = 32'h5A5A_A5A5;
    endtask

    task automatic wait_done(output int dc, output int busy_bad);
        dc = -1;
        busy_bad = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                dc = c;
                break;
            end
        end
    endtask

    task automatic run_case(input string nm, input logic [31:0] x, input logic [31:0] y,
                            input int exp_dc, input logic [2:0] exp_f);
        int dc, bb;
        launch(x, y);
        wait_done(dc, bb);
        n_checks++;
        if (dc !== exp_dc) begin
            n_fail++;
            $display("FAIL %s done_cycle got %0d expected %0d", nm, dc, exp_dc);
        end
        n_checks++;
        if ({BrEq, BrLt, BrLtU} !== exp_f) begin
            n_fail++;
            $display("FAIL %s flags got %b expected %b", nm, {BrEq, BrLt, BrLtU}, exp_f);
        end
        n_checks++;
        if (bb !== 0) begin
            n_fail++;
            $display("FAIL %s busy_low_while_active got %0d expected 0", nm, bb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        rs1 = 32'd1;
        rs2 = 32'd2;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, BrEq, BrLt, BrLtU} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected 00000", {busy, done, BrEq, BrLt, BrLtU});
        end
    endtask

    task automatic test_equal();
        run_case("equal", 32'h1234_5678, 32'h1234_5678, 5, 3'b100);
        @(negedge clk);
        n_checks++;
        if ({busy, done, BrEq} !== 3'b001) begin
            n_fail++;
            $display("FAIL equal_after busy/done/eq got %b expected 001", {busy, done, BrEq});
        end
    endtask

    task automatic test_top_chunk();
        run_case("neg_vs_pos", 32'hFFFF_FFFF, 32'h0000_0001, 2, 3'b010);
        run_case("intmin_vs_intmax", 32'h8000_0000, 32'h7FFF_FFFF, 2, 3'b010);
        run_case("intmax_vs_intmin", 32'h7FFF_FFFF, 32'h8000_0000, 2, 3'b001);
    endtask

    task automatic test_mid_chunk();
        run_case("mid_chunk", 32'h0000_0100, 32'h0000_0200, 4, 3'b011);
        run_case("low_chunk_gt", 32'h0000_0003, 32'h0000_0002, 5, 3'b000);
    endtask

    task automatic test_back_to_back();
        run_case("b2b_first", 32'h0000_0002, 32'h0000_0003, 5, 3'b011);
        run_case("b2b_second", 32'h0100_0000, 32'h0200_0000, 2, 3'b011);
    endtask

    task automatic test_start_ignored();
        int n_done = 0, first = -1;
        launch(32'd5, 32'd5);
        @(posedge clk) #1;
        start = 1'b1;
        rs1 = 32'd1;
        rs2 = 32'd9;
        @(posedge clk) #1;
        start = 1'b0;
        for (int c = 3; c <= 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first < 0) first = c;
            end
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignore_start done_count got %0d expected 1", n_done);
        end
        n_checks++;
        if (first !== 5) begin
            n_fail++;
            $display("FAIL ignore_start done_cycle got %0d expected 5", first);
        end
        n_checks++;
        if ({busy, BrEq, BrLt, BrLtU} !== 4'b0100) begin
            n_fail++;
            $display("FAIL ignore_start hold busy/flags got %b expected 0100", {busy, BrEq, BrLt, BrLtU});
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        launch(32'h0000_00AA, 32'h0000_00AA);
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, BrEq, BrLt, BrLtU} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid busy/flags got %b expected 0000", {busy, BrEq, BrLt, BrLtU});
        end
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid stray_activity got %0d expected 0", n_done);
        end
        run_case("after_reset", 32'h0000_0002, 32'h0000_0003, 5, 3'b011);
    endtask

    initial begin
        test_reset();
        test_equal();
        test_top_chunk();
        test_mid_chunk();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
